// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control/operand path.
//   - ALU control codes driven onto the ALU's ALUCtrl_i input
//   - funct3 encodings of the supported integer instructions
//   - issue FSM state type
//   - is_shift(): true for control codes whose operand 2 is a shift amount
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } issue_state_e;

  function automatic logic is_shift(input logic [2:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRA) || (ctrl == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational funct3/funct7 -> ALU control decoder.
// Ports:
//   funct3_i   instruction funct3
//   funct7_i   instruction funct7
//   is_imm_i   1 = I-type (funct7 only meaningful for shifts)
//   ctrl_o     3-bit ALU control code
//   illegal_o  operation not supported by the ALU
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       is_imm_i,
  output logic [2:0] ctrl_o,
  output logic       illegal_o
);

  logic shamt_funct7_ok;

  // I-type shifts encode the shift type in the upper immediate bits, so
  // only the two architected patterns are accepted there.
  assign shamt_funct7_ok = (funct7_i == 7'b0000000) || (funct7_i == 7'b0100000);

  always_comb begin
    ctrl_o    = ALU_ADD;
    illegal_o = 1'b0;
    unique case (funct3_i)
      F3_ADD:  ctrl_o = (!is_imm_i && funct7_i[5]) ? ALU_SUB : ALU_ADD;
      F3_AND:  ctrl_o = ALU_AND;
      F3_OR:   ctrl_o = ALU_OR;
      F3_XOR:  ctrl_o = ALU_XOR;
      F3_SLL: begin
        ctrl_o    = ALU_SLL;
        illegal_o = is_imm_i && !shamt_funct7_ok;
      end
      F3_SR: begin
        ctrl_o    = funct7_i[5] ? ALU_SRA : ALU_SRL;
        illegal_o = is_imm_i && !shamt_funct7_ok;
      end
      F3_SLT, F3_SLTU: illegal_o = 1'b1;
      default:         illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue unit between decode and the combinational ALU.
// Accepts one decoded R-/I-type instruction at a time, drives registered
// operands and control onto the ALU, samples the ALU result after
// ALU_LATENCY cycles, and presents it on a valid/ready response channel.
// Ports:
//   clk_i, rst_i                         clock, async active-high reset
//   req_valid_i / req_ready_o            request handshake
//   funct3_i, funct7_i, is_imm_i         instruction fields
//   rs1_data_i, rs2_data_i, imm_i        operand sources
//   alu_data1_o, alu_data2_o, alu_ctrl_o to the ALU
//   alu_data_i, alu_zero_i               from the ALU
//   rsp_valid_o / rsp_ready_i            response handshake
//   rsp_data_o, rsp_zero_o, rsp_err_o    captured result, zero flag, illegal op
//   op_count_o                           completed legal operations (wraps)
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic             is_imm_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic [WIDTH-1:0] imm_i,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_data_i,
  input  logic             alu_zero_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_zero_o,
  output logic             rsp_err_o,
  output logic [31:0]      op_count_o
);

  localparam logic [3:0] SETTLE_INIT = 4'(ALU_LATENCY - 1);

  issue_state_e     state_q, state_d;
  logic [3:0]       settle_q;
  logic [2:0]       dec_ctrl;
  logic             dec_illegal;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] op2_shaped;
  logic             accept;
  logic             capture;

  alu_ctrl_decode u_decode (
    .funct3_i  (funct3_i),
    .funct7_i  (funct7_i),
    .is_imm_i  (is_imm_i),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  assign op2        = is_imm_i ? imm_i : rs2_data_i;
  assign op2_shaped = is_shift(dec_ctrl) ? {{(WIDTH-5){1'b0}}, op2[4:0]} : op2;

  assign accept  = (state_q == ST_IDLE) && req_valid_i;
  assign capture = (state_q == ST_EXEC) && (settle_q == 4'd0);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid_i) state_d = dec_illegal ? ST_RESP : ST_EXEC;
      ST_EXEC: if (settle_q == 4'd0) state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    rsp_valid_o = (state_q == ST_RESP);
  end

  // Operand, settle counter and response registers. ALU-facing registers
  // load only on a legal accept so an illegal request leaves the ALU
  // inputs untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_data1_o <= '0;
      alu_data2_o <= '0;
      alu_ctrl_o  <= ALU_ADD;
      settle_q    <= '0;
      rsp_data_o  <= '0;
      rsp_zero_o  <= 1'b0;
      rsp_err_o   <= 1'b0;
      op_count_o  <= '0;
    end else begin
      if (accept) begin
        if (dec_illegal) begin
          rsp_data_o <= '0;
          rsp_zero_o <= 1'b0;
          rsp_err_o  <= 1'b1;
        end else begin
          alu_data1_o <= rs1_data_i;
          alu_data2_o <= op2_shaped;
          alu_ctrl_o  <= dec_ctrl;
          settle_q    <= SETTLE_INIT;
        end
      end
      if (state_q == ST_EXEC && !capture) settle_q <= settle_q - 4'd1;
      if (capture) begin
        rsp_data_o <= alu_data_i;
        rsp_zero_o <= alu_zero_i;
        rsp_err_o  <= 1'b0;
        op_count_o <= op_count_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference ALU: {zero, result}
  function automatic logic [32:0] alu_model(input logic [2:0] ctrl,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (ctrl)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = a << b[4:0];
      3'b110:  r = $unsigned($signed(a) >>> b[4:0]);
      default: r = a >> b[4:0];
    endcase
    return {(r == 32'd0), r};
  endfunction

  // ---------------- DUT A: ALU_LATENCY = 1 ----------------
  logic        a_rst, a_req_valid, a_req_ready, a_is_imm, a_alu_zero;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_zero, a_rsp_err;
  logic [2:0]  a_funct3, a_alu_ctrl;
  logic [6:0]  a_funct7;
  logic [31:0] a_rs1, a_rs2, a_imm, a_alu_d1, a_alu_d2, a_alu_data, a_rsp_data, a_op_count;

  assign {a_alu_zero, a_alu_data} = alu_model(a_alu_ctrl, a_alu_d1, a_alu_d2);

  alu_issue_unit #(.WIDTH(32), .ALU_LATENCY(1)) u_dut_a (
    .clk_i(clk), .rst_i(a_rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
    .funct3_i(a_funct3), .funct7_i(a_funct7), .is_imm_i(a_is_imm),
    .rs1_data_i(a_rs1), .rs2_data_i(a_rs2), .imm_i(a_imm),
    .alu_data1_o(a_alu_d1), .alu_data2_o(a_alu_d2), .alu_ctrl_o(a_alu_ctrl),
    .alu_data_i(a_alu_data), .alu_zero_i(a_alu_zero),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_data_o(a_rsp_data), .rsp_zero_o(a_rsp_zero), .rsp_err_o(a_rsp_err),
    .op_count_o(a_op_count)
  );

  // ---------------- DUT B: ALU_LATENCY = 4 ----------------
  logic        b_rst, b_req_valid, b_req_ready, b_is_imm, b_alu_zero;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_zero, b_rsp_err;
  logic [2:0]  b_funct3, b_alu_ctrl;
  logic [6:0]  b_funct7;
  logic [31:0] b_rs1, b_rs2, b_imm, b_alu_d1, b_alu_d2, b_alu_data, b_rsp_data, b_op_count;

  assign {b_alu_zero, b_alu_data} = alu_model(b_alu_ctrl, b_alu_d1, b_alu_d2);

  alu_issue_unit #(.WIDTH(32), .ALU_LATENCY(4)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .funct3_i(b_funct3), .funct7_i(b_funct7), .is_imm_i(b_is_imm),
    .rs1_data_i(b_rs1), .rs2_data_i(b_rs2), .imm_i(b_imm),
    .alu_data1_o(b_alu_d1), .alu_data2_o(b_alu_d2), .alu_ctrl_o(b_alu_ctrl),
    .alu_data_i(b_alu_data), .alu_zero_i(b_alu_zero),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_data_o(b_rsp_data), .rsp_zero_o(b_rsp_zero), .rsp_err_o(b_rsp_err),
    .op_count_o(b_op_count)
  );

  // Present one request to DUT A and hold it for exactly the accepting edge.
  task automatic a_send(input logic [2:0] f3, input logic [6:0] f7, input logic imm_sel,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    int unsigned n = 0;
    while (!a_req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_before_send", {31'd0, a_req_ready}, 32'd1);
    a_funct3 = f3; a_funct7 = f7; a_is_imm = imm_sel;
    a_rs1 = rs1; a_rs2 = rs2; a_imm = imm;
    a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until rsp_valid_o is seen.
  task automatic a_wait_rsp(input string tag, input int unsigned exp_edges);
    int unsigned n = 0;
    while (!a_rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check(tag, n, exp_edges);
  endtask

  task automatic a_release();
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, a_rsp_valid}, 32'd0);
    check("req_ready_back", {31'd0, a_req_ready}, 32'd1);
  endtask

  initial begin
    bit saw_valid;
    int unsigned n;

    a_rst = 1'b1; a_req_valid = 1'b0; a_rsp_ready = 1'b0;
    a_funct3 = '0; a_funct7 = '0; a_is_imm = 1'b0; a_rs1 = '0; a_rs2 = '0; a_imm = '0;
    b_rst = 1'b1; b_req_valid = 1'b0; b_rsp_ready = 1'b0;
    b_funct3 = '0; b_funct7 = '0; b_is_imm = 1'b0; b_rs1 = '0; b_rs2 = '0; b_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("rst_rsp_data",  a_rsp_data, 32'd0);
    check("rst_rsp_zero",  {31'd0, a_rsp_zero}, 32'd0);
    check("rst_rsp_err",   {31'd0, a_rsp_err}, 32'd0);
    check("rst_alu_d1",    a_alu_d1, 32'd0);
    check("rst_alu_d2",    a_alu_d2, 32'd0);
    check("rst_alu_ctrl",  {29'd0, a_alu_ctrl}, 32'd0);
    check("rst_op_count",  a_op_count, 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;

    // R-type add
    a_send(3'b000, 7'h00, 1'b0, 32'h10, 32'h20, 32'h0);
    check("add_ctrl", {29'd0, a_alu_ctrl}, 32'd0);
    a_wait_rsp("add_latency", 1);
    check("add_data", a_rsp_data, 32'h30);
    check("add_zero", {31'd0, a_rsp_zero}, 32'd0);
    check("add_err",  {31'd0, a_rsp_err}, 32'd0);
    check("add_count", a_op_count, 32'd1);
    // held while rsp_ready low for one extra cycle
    @(posedge clk); #1;
    check("add_hold_valid", {31'd0, a_rsp_valid}, 32'd1);
    a_release();

    // R-type sub, equal operands
    a_send(3'b000, 7'h20, 1'b0, 32'h20, 32'h20, 32'h0);
    check("sub_ctrl", {29'd0, a_alu_ctrl}, 32'd1);
    a_wait_rsp("sub_latency", 1);
    check("sub_data", a_rsp_data, 32'h0);
    check("sub_zero", {31'd0, a_rsp_zero}, 32'd1);
    check("sub_count", a_op_count, 32'd2);
    a_release();

    // I-type srai: shift amount taken from imm[4:0]
    a_send(3'b101, 7'h20, 1'b1, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 32'h402);
    check("srai_ctrl", {29'd0, a_alu_ctrl}, 32'd6);
    check("srai_d2",   a_alu_d2, 32'd2);
    a_wait_rsp("srai_latency", 1);
    check("srai_data", a_rsp_data, 32'hFFFF_FFFC);
    a_release();

    // I-type srli
    a_send(3'b101, 7'h00, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h2);
    check("srli_ctrl", {29'd0, a_alu_ctrl}, 32'd7);
    a_wait_rsp("srli_latency", 1);
    check("srli_data", a_rsp_data, 32'h3FFF_FFFC);
    check("srli_count", a_op_count, 32'd4);
    a_release();

    // Illegal slt: immediate error response, ALU inputs untouched
    a_send(3'b010, 7'h00, 1'b0, 32'h1234, 32'h5678, 32'h0);
    a_wait_rsp("slt_latency", 0);
    check("slt_err",   {31'd0, a_rsp_err}, 32'd1);
    check("slt_data",  a_rsp_data, 32'd0);
    check("slt_zero",  {31'd0, a_rsp_zero}, 32'd0);
    check("slt_count", a_op_count, 32'd4);
    check("slt_ctrl_kept", {29'd0, a_alu_ctrl}, 32'd7);
    check("slt_d1_kept", a_alu_d1, 32'hFFFF_FFF0);
    check("slt_d2_kept", a_alu_d2, 32'd2);
    a_release();

    // I-type addi with funct7 bit 5 set stays an add
    a_send(3'b000, 7'h20, 1'b1, 32'd5, 32'd100, 32'd3);
    check("addi_ctrl", {29'd0, a_alu_ctrl}, 32'd0);
    a_wait_rsp("addi_latency", 1);
    check("addi_data", a_rsp_data, 32'd8);
    check("addi_err",  {31'd0, a_rsp_err}, 32'd0);
    check("addi_count", a_op_count, 32'd5);
    a_release();

    // I-type slli with a non-architected funct7 is illegal
    a_send(3'b001, 7'h01, 1'b1, 32'd1, 32'd0, 32'd4);
    a_wait_rsp("slli_bad_latency", 0);
    check("slli_bad_err", {31'd0, a_rsp_err}, 32'd1);
    check("slli_bad_count", a_op_count, 32'd5);
    a_release();

    // R-type sll: only rs2[4:0] reaches the ALU
    a_send(3'b001, 7'h00, 1'b0, 32'd1, 32'h23, 32'h0);
    check("sll_d2", a_alu_d2, 32'd3);
    a_wait_rsp("sll_latency", 1);
    check("sll_data", a_rsp_data, 32'd8);
    check("sll_count", a_op_count, 32'd6);
    a_release();

    // Backpressure on xor, with a competing request held valid
    a_send(3'b100, 7'h00, 1'b0, 32'hF0, 32'h0F, 32'h0);
    a_wait_rsp("xor_latency", 1);
    a_funct3 = 3'b111; a_funct7 = 7'h00; a_is_imm = 1'b0;
    a_rs1 = 32'hF0; a_rs2 = 32'h3C;
    a_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",     {31'd0, a_rsp_valid}, 32'd1);
      check("bp_data",      a_rsp_data, 32'hFF);
      check("bp_req_ready", {31'd0, a_req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    check("bp_count", a_op_count, 32'd7);
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    check("bp_rsp_drop",  {31'd0, a_rsp_valid}, 32'd0);
    check("bp_idle",      {31'd0, a_req_ready}, 32'd1);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    check("bp_accepted",  {31'd0, a_req_ready}, 32'd0);
    check("and_ctrl",     {29'd0, a_alu_ctrl}, 32'd2);
    a_wait_rsp("and_latency", 1);
    check("and_data",  a_rsp_data, 32'h30);
    check("and_count", a_op_count, 32'd8);
    a_release();

    // ---------------- DUT B ----------------
    // Full transaction at ALU_LATENCY=4
    b_funct3 = 3'b000; b_funct7 = 7'h00; b_is_imm = 1'b0; b_rs1 = 32'd7; b_rs2 = 32'd8;
    b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    n = 0;
    while (!b_rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("b_latency", n, 32'd4);
    check("b_data",  b_rsp_data, 32'd15);
    check("b_count", b_op_count, 32'd1);
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;

    // Second request, reset asynchronously in the middle of the settle count
    b_rs1 = 32'd100; b_rs2 = 32'd1;
    b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    check("b_exec_busy", {31'd0, b_req_ready}, 32'd0);
    @(posedge clk); #2;
    b_rst = 1'b1;
    #1;
    check("b_rst_req_ready", {31'd0, b_req_ready}, 32'd1);
    check("b_rst_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    check("b_rst_count",     b_op_count, 32'd0);
    check("b_rst_d1",        b_alu_d1, 32'd0);
    check("b_rst_d2",        b_alu_d2, 32'd0);
    check("b_rst_rsp_data",  b_rsp_data, 32'd0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      saw_valid = saw_valid | b_rsp_valid;
    end
    check("b_no_rsp_after_rst", {31'd0, saw_valid}, 32'd0);
    check("b_count_after_rst", b_op_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Initiator side of the ALU control/operand interface: accepts decoded R-/I-type integer instructions over a valid/ready request channel and translates funct3/funct7 into the 3-bit ALU control code.
- Drives the operands onto the combinational ALU, samples data_o/zero_o after a fixed settle delay, and returns the result on a valid/ready response channel.
- Sits between the decode stage and the ALU in the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width.
- ALU_LATENCY, 1, cycles operands are held on the ALU before the result is sampled (legal range 1..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- funct3_i  in  3  instruction funct3.
- funct7_i  in  7  instruction funct7.
- is_imm_i  in  1  1 = I-type, operand2 taken from imm_i.
- rs1_data_i  in  WIDTH  operand 1.
- rs2_data_i  in  WIDTH  operand 2 (R-type).
- imm_i  in  WIDTH  sign-extended immediate (I-type).
- alu_data1_o  out  WIDTH  to ALU data1_i.
- alu_data2_o  out  WIDTH  to ALU data2_i.
- alu_ctrl_o  out  3  to ALU ALUCtrl_i.
- alu_data_i  in  WIDTH  from ALU data_o.
- alu_zero_i  in  1  from ALU zero_o.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_data_o  out  WIDTH  captured result.
- rsp_zero_o  out  1  captured zero flag.
- rsp_err_o  out  1  illegal operation (no ALU issue).
- op_count_o  out  32  count of completed legal operations (wraps).

Behaviour:
- Interface decided: one clock; reset is asynchronous and active-high (clk_i, rst_i).
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_zero_o=0, rsp_err_o=0, alu_data1_o=0, alu_data2_o=0, alu_ctrl_o=3'b000, op_count_o=0.
- Decode (funct3 → alu_ctrl):
  - 000 → 000 (add), or 001 (sub) when R-type and funct7[5]=1; I-type ignores funct7.
  - 111 → 010 (and).
  - 110 → 011 (or).
  - 100 → 100 (xor).
  - 001 → 101 (sll).
  - 101 → 110 (sra) if funct7[5]=1, else 111 (srl).
  - 010, 011 → illegal.
  - I-type shift with funct7 other than 0000000/0100000 → illegal.
- Shift operand: for ctrl 101/110/111, alu_data2_o = {zeros, op2[4:0]}; otherwise alu_data2_o = op2, where op2 = is_imm_i ? imm_i : rs2_data_i.
- FSM IDLE:
  - req_ready_o=1.
  - On req_valid_i: register operands and ctrl.
  - Legal → EXEC, load settle counter with ALU_LATENCY-1.
  - Illegal → RESP with rsp_err_o=1, rsp_data_o=0, rsp_zero_o=0; op_count_o unchanged.
- FSM EXEC:
  - req_ready_o=0; ALU outputs held stable.
  - Counter decrements each cycle; when it is 0, capture alu_data_i/alu_zero_i into rsp regs, rsp_err_o=0, increment op_count_o → RESP.
  - Latency from accept to rsp_valid_o = ALU_LATENCY+1 cycles.
- FSM RESP:
  - rsp_valid_o=1; rsp_* held stable while rsp_ready_i=0.
  - On rsp_ready_i → IDLE, rsp_valid_o=0 next cycle.
- No request/response overlap: req_ready_o is 0 outside IDLE.
- ALU operand regs keep their last value in IDLE/RESP, with no glitching.
- op_count_o wraps 0xFFFFFFFF → 0.
- rst_i mid-EXEC or mid-RESP: immediate return to reset values; the pending response is discarded.
- Request inputs are ignored when req_ready_o=0.

Decomposition:
- Shared package alu_pkg:
  - ALU control localparams ALU_ADD..ALU_SRL (3'b000..3'b111).
  - funct3 constants.
  - FSM state enum (IDLE/EXEC/RESP).
- One natural sub-module: alu_ctrl_decode, a combinational funct3/funct7/is_imm → {ctrl, illegal}. It is reusable by the future pipelined control path.
- The bench instantiates the existing ALU and connects it to the alu_* ports.

Test Plan:
- R-type add: funct3=000, funct7=0, rs1=0x10, rs2=0x20 → alu_ctrl_o=000; rsp_data_o=0x30, rsp_zero_o=0, rsp_valid_o 2 cycles after accept (ALU_LATENCY=1); op_count_o=1.
- R-type sub equal: funct7=0x20, rs1=rs2=0x20 → ctrl 001; rsp_data_o=0, rsp_zero_o=1.
- I-type srai: funct3=101, funct7=0x20, rs1=0xFFFFFFF0, imm=0x402 → alu_data2_o=2, ctrl 110, rsp_data_o=0xFFFFFFFC. Then srli with imm=2 → ctrl 111, 0x3FFFFFFC.
- Illegal slt: funct3=010 → rsp_err_o=1, rsp_data_o=0, op_count_o unchanged, ALU outputs unchanged.
- Backpressure: rsp_ready_i=0 for 5 cycles after an xor 0xF0^0x0F → rsp_data_o=0xFF held; req_ready_o=0 and a new req_valid_i is ignored; accepted 1 cycle after rsp_ready_i rises.
- Reset during EXEC with ALU_LATENCY=4: assert rst_i asynchronously mid-count → all outputs return to reset values immediately; no response is ever emitted.
